// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller for a TMS9918-style VDP: I/O decode, VRAM pointer and
// read-ahead buffer, register file, status flags and CPU/video VRAM arbitration.
module vdp_port_ctrl #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic        port_sel,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_gnt,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  input  logic        vblank,
  input  logic        coll,
  output logic [63:0] regs,
  output logic        n_int,
  output logic        busy,
  output logic        overrun
);

  localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [13:0]   addr;
  logic [7:0]    latch;
  logic          toggle;
  logic [7:0]    read_buf;
  logic          flag_f;
  logic          flag_c;
  logic          pend;
  logic          pend_we;
  logic [7:0]    pend_data;
  logic          rd_cap;
  logic [CW-1:0] starve_cnt;
  logic [63:0]   reg_file;
  logic          overrun_q;

  logic        cpu_slot;
  logic        wr_ctrl;
  logic        wr_data;
  logic        rd_data;
  logic        rd_stat;
  logic        setup_byte;
  logic        vram_access;
  logic [7:0]  status;

  always_comb begin
    wr_ctrl     = io_wr & port_sel;
    wr_data     = io_wr & ~port_sel;
    rd_data     = io_rd & ~io_wr & ~port_sel;
    rd_stat     = io_rd & ~io_wr & port_sel;
    setup_byte  = wr_ctrl & toggle & ~cpu_din[7];
    vram_access = setup_byte | wr_data | rd_data;
    // A pending CPU access takes the slot when video is idle or has starved it long enough.
    cpu_slot    = pend & ~reset & (~vid_req | (starve_cnt == SMAX));
    status      = {flag_f, 1'b0, flag_c, 5'b00000};
  end

  assign busy       = pend | rd_cap;
  assign vid_gnt    = vid_req & ~cpu_slot;
  assign vram_addr  = cpu_slot ? addr : vid_addr;
  assign vram_we    = cpu_slot & pend_we;
  assign vram_wdata = pend_data;
  assign cpu_dout   = port_sel ? status : read_buf;
  assign regs       = reg_file;
  assign n_int      = ~(flag_f & reg_file[13]);
  assign overrun    = overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      latch      <= '0;
      toggle     <= 1'b0;
      read_buf   <= '0;
      flag_f     <= 1'b0;
      flag_c     <= 1'b0;
      pend       <= 1'b0;
      pend_we    <= 1'b0;
      pend_data  <= '0;
      rd_cap     <= 1'b0;
      starve_cnt <= '0;
      reg_file   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (wr_ctrl)
        toggle <= ~toggle;
      else if (wr_data | rd_data | rd_stat)
        toggle <= 1'b0;

      if (wr_ctrl & ~toggle)
        latch <= cpu_din;

      if (wr_ctrl & toggle & cpu_din[7] & (cpu_din[6:3] == 4'b0000))
        reg_file[{cpu_din[2:0], 3'b000} +: 8] <= latch;

      // Flag set wins over the clear caused by a status read in the same cycle.
      flag_f <= vblank | (flag_f & ~rd_stat);
      flag_c <= coll | (flag_c & ~rd_stat);

      if (vram_access & busy)
        overrun_q <= 1'b1;

      if (rd_cap) begin
        read_buf <= vram_rdata;
        rd_cap   <= 1'b0;
      end

      if (cpu_slot) begin
        addr       <= addr + 14'd1;
        pend       <= 1'b0;
        starve_cnt <= '0;
        rd_cap     <= ~pend_we;
      end else if (pend) begin
        starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      if (~busy) begin
        if (setup_byte) begin
          addr <= {cpu_din[5:0], latch};
          if (~cpu_din[6]) begin
            pend    <= 1'b1;
            pend_we <= 1'b0;
          end
        end else if (wr_data) begin
          pend      <= 1'b1;
          pend_we   <= 1'b1;
          pend_data <= cpu_din;
          read_buf  <= cpu_din;
        end else if (rd_data) begin
          pend    <= 1'b1;
          pend_we <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Testbench for vdp_port_ctrl: directed vector table, corner-case sequences and
// randomized transactions checked against a transaction-level model.
module tb_vdp_port_ctrl;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset, io_wr, io_rd, port_sel, vid_req, vblank, coll;
  logic [7:0]  cpu_din, cpu_dout, vram_wdata, vram_rdata;
  logic [13:0] vid_addr, vram_addr;
  logic        vid_gnt, vram_we, n_int, busy, overrun;
  logic [63:0] regs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vdp_port_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .port_sel(port_sel),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .vblank(vblank), .coll(coll), .regs(regs), .n_int(n_int),
    .busy(busy), .overrun(overrun)
  );

  // VRAM: registered read, tagged so a new test phase starts from known default contents
  bit [7:0] vmem [16384];
  bit [3:0] vtag [16384];
  bit [3:0] cur_tag = 4'd1;
  int       wr_count = 0;
  logic [13:0] last_wa;
  logic [7:0]  last_wd;

  function automatic logic [7:0] init_val(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  always @(posedge clk) begin
    if (vram_we === 1'b1) begin
      vmem[vram_addr] <= vram_wdata;
      vtag[vram_addr] <= cur_tag;
      wr_count <= wr_count + 1;
      last_wa  <= vram_addr;
      last_wd  <= vram_wdata;
    end
    vram_rdata <= (vtag[vram_addr] == cur_tag) ? vmem[vram_addr] : init_val(vram_addr);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic sel, input logic [7:0] din,
                               input logic vreq, input logic vbl, input logic col);
    io_wr = wr; io_rd = rd; port_sel = sel; cpu_din = din;
    vid_req = vreq; vblank = vbl; coll = col;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    io_wr = 1'b0; io_rd = 1'b0; vblank = 1'b0; coll = 1'b0;
  endtask

  task automatic do_cycle(input logic wr, input logic rd, input logic sel, input logic [7:0] din);
    applyStimulus(wr, rd, sel, din, vid_req, 1'b0, 1'b0);
    settle();
    advance();
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int n = 0; n < 20 && !idle; n++) begin
      settle();
      idle = !busy;
      advance();
    end
    checkOutput({name, " idle"}, idle, 1'b1);
  endtask

  typedef struct {
    logic wr, rd, sel; logic [7:0] din; logic vreq, vbl, col;
    logic gnt, we, bsy, nint; logic chkd; logic [7:0] dout; logic chkva; logic [13:0] va; logic [7:0] wd;
  } vec_t;

  function automatic vec_t V(logic wr, logic rd, logic sel, logic [7:0] din, logic vreq, logic vbl, logic col,
                             logic gnt, logic we, logic bsy, logic nint, logic chkd, logic [7:0] dout,
                             logic chkva, logic [13:0] va, logic [7:0] wd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.sel = sel; v.din = din; v.vreq = vreq; v.vbl = vbl; v.col = col;
    v.gnt = gnt; v.we = we; v.bsy = bsy; v.nint = nint; v.chkd = chkd; v.dout = dout;
    v.chkva = chkva; v.va = va; v.wd = wd;
    return v;
  endfunction

  // Transaction-level reference model
  logic [7:0]  m_mem [16384];
  logic [13:0] m_addr;
  logic [7:0]  m_rbuf;
  logic [7:0]  m_regs [8];
  logic        m_f, m_c, m_over;

  function automatic logic [63:0] m_regs_packed();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  task automatic strobe_cycle(input logic wr, input logic rd, input logic sel, input logic [7:0] din);
    logic vr, vb, cl;
    vr = ($urandom_range(0, 1) == 1);
    vb = ($urandom_range(0, 7) == 0);
    cl = ($urandom_range(0, 7) == 0);
    applyStimulus(wr, rd, sel, din, vr, vb, cl);
    settle();
    checkOutput("rnd strobe gnt", vid_gnt, vr);
    checkOutput("rnd strobe we", vram_we, 1'b0);
    if (rd && sel) checkOutput("rnd status", cpu_dout, {m_f, 1'b0, m_c, 5'b0});
    if (rd && !sel) checkOutput("rnd data read", cpu_dout, m_rbuf);
    advance();
    if (rd && sel) begin m_f = vb; m_c = cl; end
    else begin m_f = m_f | vb; m_c = m_c | cl; end
  endtask

  task automatic access(input logic is_write, input logic [7:0] d);
    logic vr [STARVE_MAX+1];
    int k;
    bit drop;
    for (int i = 0; i <= STARVE_MAX; i++) vr[i] = ($urandom_range(0, 2) != 0);
    k = STARVE_MAX;
    for (int i = STARVE_MAX; i >= 0; i--) if (!vr[i]) k = i;
    drop = ($urandom_range(0, 5) == 0);
    for (int i = 0; i <= k; i++) begin
      if (i == 0 && drop) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom), vr[i], 1'b0, 1'b0);
      else applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, vr[i], 1'b0, 1'b0);
      settle();
      checkOutput("rnd busy pend", busy, 1'b1);
      if (i < k) begin
        checkOutput("rnd video gnt", vid_gnt, 1'b1);
        checkOutput("rnd video we", vram_we, 1'b0);
        checkOutput("rnd video addr", vram_addr, vid_addr);
      end else begin
        checkOutput("rnd slot gnt", vid_gnt, 1'b0);
        checkOutput("rnd slot we", vram_we, is_write);
        checkOutput("rnd slot addr", vram_addr, m_addr);
        if (is_write) checkOutput("rnd slot wdata", vram_wdata, d);
      end
      advance();
    end
    if (drop) m_over = 1'b1;
    if (is_write) begin m_mem[m_addr] = d; m_rbuf = d; end
    else m_rbuf = m_mem[m_addr];
    m_addr = m_addr + 14'd1;
    if (!is_write) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      settle();
      checkOutput("rnd capture busy", busy, 1'b1);
      checkOutput("rnd capture gnt", vid_gnt, vid_req);
      advance();
    end
  endtask

  task automatic idle_check();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("rnd idle busy", busy, 1'b0);
    checkOutput("rnd read_buf", cpu_dout, m_rbuf);
    checkOutput("rnd regs", regs, m_regs_packed());
    checkOutput("rnd n_int", n_int, !(m_f && m_regs[1][5]));
    checkOutput("rnd overrun", overrun, m_over);
    advance();
  endtask

  initial begin
    vec_t tbl[$];
    int wc0;
    logic [13:0] a;
    logic [7:0]  d;
    int op;
    int r;

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vid_addr = 14'h2AAA;
    reset = 1'b1;
    advance();
    advance();
    settle();
    checkOutput("reset gnt", vid_gnt, 1'b1);
    checkOutput("reset we", vram_we, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset n_int", n_int, 1'b1);
    checkOutput("reset overrun", overrun, 1'b0);
    checkOutput("reset regs", regs, 64'h0);
    checkOutput("reset dout", cpu_dout, 8'h00);
    advance();
    reset = 1'b0;

    //            wr rd sel din   vrq vbl col | gnt we bsy nint chkd dout  chkva va        wd
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, 0,   1, 0, 0, 1,   1, 8'h00, 1, 14'h2AAA, 8'h00));
    tbl.push_back(V(1, 0, 1, 8'h00, 0, 0, 0,   0, 0, 0, 1,   1, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(1, 0, 1, 8'h41, 0, 0, 0,   0, 0, 0, 1,   0, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(1, 0, 0, 8'hAA, 0, 0, 0,   0, 0, 0, 1,   1, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, 0,   0, 1, 1, 1,   1, 8'hAA, 1, 14'h0100, 8'hAA));
    tbl.push_back(V(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 1,   1, 8'hAA, 0, 14'h0000, 8'h00));
    tbl.push_back(V(1, 0, 0, 8'h55, 1, 0, 0,   1, 0, 0, 1,   0, 8'h00, 1, 14'h2AAA, 8'h00));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, 0,   1, 0, 1, 1,   1, 8'h55, 1, 14'h2AAA, 8'h00));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, 0,   1, 0, 1, 1,   0, 8'h00, 1, 14'h2AAA, 8'h00));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, 0,   1, 0, 1, 1,   0, 8'h00, 1, 14'h2AAA, 8'h00));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, 0,   0, 1, 1, 1,   0, 8'h00, 1, 14'h0101, 8'h55));
    tbl.push_back(V(0, 0, 0, 8'h00, 1, 0, 0,   1, 0, 0, 1,   0, 8'h00, 1, 14'h2AAA, 8'h00));
    tbl.push_back(V(1, 0, 1, 8'hE0, 0, 0, 0,   0, 0, 0, 1,   0, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(1, 0, 1, 8'h81, 0, 0, 0,   0, 0, 0, 1,   0, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 0, 1, 8'h00, 0, 1, 0,   0, 0, 0, 1,   1, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 1, 1, 8'h00, 0, 0, 0,   0, 0, 0, 0,   1, 8'h80, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 0, 1, 8'h00, 0, 0, 0,   0, 0, 0, 1,   1, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 0, 1, 8'h00, 0, 0, 1,   0, 0, 0, 1,   1, 8'h00, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 1, 1, 8'h00, 0, 0, 1,   0, 0, 0, 1,   1, 8'h20, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 0, 1, 8'h00, 0, 0, 0,   0, 0, 0, 1,   1, 8'h20, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 1, 1, 8'h00, 0, 0, 0,   0, 0, 0, 1,   1, 8'h20, 0, 14'h0000, 8'h00));
    tbl.push_back(V(0, 0, 1, 8'h00, 0, 0, 0,   0, 0, 0, 1,   1, 8'h00, 0, 14'h0000, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].wr, tbl[i].rd, tbl[i].sel, tbl[i].din, tbl[i].vreq, tbl[i].vbl, tbl[i].col);
      settle();
      checkOutput($sformatf("vec%0d gnt", i), vid_gnt, tbl[i].gnt);
      checkOutput($sformatf("vec%0d we", i), vram_we, tbl[i].we);
      checkOutput($sformatf("vec%0d busy", i), busy, tbl[i].bsy);
      checkOutput($sformatf("vec%0d n_int", i), n_int, tbl[i].nint);
      if (tbl[i].chkd) checkOutput($sformatf("vec%0d dout", i), cpu_dout, tbl[i].dout);
      if (tbl[i].chkva) checkOutput($sformatf("vec%0d vram_addr", i), vram_addr, tbl[i].va);
      if (tbl[i].we) checkOutput($sformatf("vec%0d wdata", i), vram_wdata, tbl[i].wd);
      advance();
    end
    checkOutput("table regs", regs, 64'h0000_0000_0000_E000);

    // Read setup with prefetch, then a data read returning the prefetched byte
    vid_req = 1'b0;
    do_cycle(1, 0, 1, 8'h34); do_cycle(1, 0, 1, 8'h52);
    do_cycle(1, 0, 0, 8'h5C); wait_idle("seqA w1");
    do_cycle(1, 0, 0, 8'h99); wait_idle("seqA w2");
    do_cycle(1, 0, 1, 8'h34); do_cycle(1, 0, 1, 8'h12);
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 0);
    settle();
    checkOutput("seqA slot addr", vram_addr, 14'h1234);
    checkOutput("seqA slot we", vram_we, 1'b0);
    checkOutput("seqA slot busy", busy, 1'b1);
    advance();
    settle();
    checkOutput("seqA capture busy", busy, 1'b1);
    checkOutput("seqA old read_buf", cpu_dout, 8'h99);
    advance();
    settle();
    checkOutput("seqA done busy", busy, 1'b0);
    checkOutput("seqA read_buf", cpu_dout, 8'h5C);
    advance();
    applyStimulus(0, 1, 0, 8'h00, 0, 0, 0);
    settle();
    checkOutput("seqA data read", cpu_dout, 8'h5C);
    advance();
    settle();
    checkOutput("seqA next addr", vram_addr, 14'h1235);
    advance();
    wait_idle("seqA prefetch");
    settle();
    checkOutput("seqA prefetch data", cpu_dout, 8'h99);
    advance();

    // Address wrap
    do_cycle(1, 0, 1, 8'hFF); do_cycle(1, 0, 1, 8'h7F);
    do_cycle(1, 0, 0, 8'h11); wait_idle("seqB w1");
    checkOutput("seqB first addr", last_wa, 14'h3FFF);
    checkOutput("seqB first data", last_wd, 8'h11);
    do_cycle(1, 0, 0, 8'h22); wait_idle("seqB w2");
    checkOutput("seqB wrap addr", last_wa, 14'h0000);
    checkOutput("seqB wrap data", last_wd, 8'h22);

    // Access dropped while busy; status read resets the control byte toggle
    checkOutput("seqC overrun before", overrun, 1'b0);
    wc0 = wr_count;
    vid_req = 1'b1;
    do_cycle(1, 0, 0, 8'h33);
    do_cycle(1, 0, 0, 8'h44);
    vid_req = 1'b0;
    wait_idle("seqC");
    checkOutput("seqC write count", wr_count - wc0, 1);
    checkOutput("seqC kept data", last_wd, 8'h33);
    checkOutput("seqC overrun", overrun, 1'b1);
    do_cycle(1, 0, 1, 8'h00);
    do_cycle(0, 1, 1, 8'h00);
    do_cycle(1, 0, 1, 8'h41);
    do_cycle(1, 0, 1, 8'h81);
    settle();
    checkOutput("seqC reg1", regs[15:8], 8'h41);
    advance();

    // Reset arriving on the CPU slot cycle
    wc0 = wr_count;
    vid_req = 1'b1;
    do_cycle(1, 0, 0, 8'h66);
    for (int i = 0; i < STARVE_MAX; i++) do_cycle(0, 0, 0, 8'h00);
    reset = 1'b1;
    settle();
    checkOutput("seqD reset we", vram_we, 1'b0);
    checkOutput("seqD reset gnt", vid_gnt, 1'b1);
    advance();
    reset = 1'b0;
    vid_req = 1'b0;
    settle();
    checkOutput("seqD busy", busy, 1'b0);
    checkOutput("seqD overrun", overrun, 1'b0);
    checkOutput("seqD regs", regs, 64'h0);
    advance();
    do_cycle(0, 0, 0, 8'h00);
    do_cycle(0, 0, 0, 8'h00);
    checkOutput("seqD no write", wr_count - wc0, 0);

    // Randomized transactions against the model
    cur_tag = 4'd2;
    for (int i = 0; i < 16384; i++) m_mem[i] = init_val(14'(i));
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_addr = 14'h0; m_rbuf = 8'h00; m_f = 1'b0; m_c = 1'b0; m_over = 1'b0;
    for (int t = 0; t < 200; t++) begin
      vid_addr = 14'($urandom);
      op = $urandom_range(0, 5);
      a = 14'($urandom);
      d = 8'($urandom);
      case (op)
        0: begin
          r = $urandom_range(0, 7);
          strobe_cycle(1, 0, 1, d);
          m_latch_write(d);
          if ($urandom_range(0, 3) == 0) begin
            strobe_cycle(1, 0, 1, {1'b1, 4'($urandom_range(1, 15)), 3'(r)});
          end else begin
            strobe_cycle(1, 0, 1, {1'b1, 4'b0000, 3'(r)});
            m_regs[r] = d;
          end
        end
        1: begin
          strobe_cycle(1, 0, 1, a[7:0]);
          strobe_cycle(1, 0, 1, {2'b01, a[13:8]});
          m_addr = a;
        end
        2: begin
          strobe_cycle(1, 0, 1, a[7:0]);
          strobe_cycle(1, 0, 1, {2'b00, a[13:8]});
          m_addr = a;
          access(1'b0, 8'h00);
        end
        3: begin
          strobe_cycle(1, 0, 0, d);
          access(1'b1, d);
        end
        4: begin
          strobe_cycle(0, 1, 0, 8'h00);
          access(1'b0, 8'h00);
        end
        default: strobe_cycle(0, 1, 1, 8'h00);
      endcase
      idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // The latch is not visible at the ports; kept only so the model reads naturally.
  logic [7:0] m_latch;
  task automatic m_latch_write(input logic [7:0] v);
    m_latch = v;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/vdp_port_ctrl.md
# vdp_port_ctrl

CPU-side controller for the TMS9918-style video processor: decodes I/O accesses to the data port (0x98) and control port (0x99), keeps the VRAM address pointer, read-ahead buffer, the 8 VDP registers and the status flags, and arbitrates a single-port 16 KB VRAM between CPU accesses and the video fetch engine. It sits between the Z80 I/O decode and the video block, replacing ad-hoc port logic in the top level.

## Interface

Parameters:
- STARVE_MAX, 3: consecutive video-won cycles a pending CPU access tolerates before it preempts video.

Ports:
- clk  in  1  system clock (cpuClock domain)
- reset  in  1  synchronous, active-high
- io_wr  in  1  one-cycle strobe: CPU I/O write to this block
- io_rd  in  1  one-cycle strobe: CPU I/O read from this block
- port_sel  in  1  0 = data port (0x98), 1 = control port (0x99)
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  read data; combinational: port_sel ? status : read_buf
- vid_req  in  1  video fetch requests VRAM this cycle
- vid_addr  in  14  video fetch address
- vid_gnt  out  1  video owns VRAM this cycle (data on vram_rdata next cycle)
- vram_addr  out  14  VRAM address (muxed)
- vram_we  out  1  VRAM write enable
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data, valid 1 cycle after address
- vblank  in  1  one-cycle pulse at start of vertical blank
- coll  in  1  one-cycle pulse on sprite collision
- regs  out  64  VDP registers, reg n at [8n+7:8n]
- n_int  out  1  interrupt, low while F flag set and reg1[5] = 1
- busy  out  1  CPU VRAM access pending or read capture in progress
- overrun  out  1  sticky: a VRAM-affecting access was dropped while busy; cleared by reset only

## Operation

- State: addr (14), latch (8), toggle, read_buf (8), F, C, pend, pend_we, pend_data, rd_cap, starve_cnt (2).
- Control write, toggle = 0: latch <= cpu_din, toggle <= 1.
- Control write, toggle = 1: toggle <= 0; then
  - cpu_din[7] = 1: if cpu_din[6:3] = 0, reg[cpu_din[2:0]] <= latch; else ignored. Allowed while busy.
  - cpu_din[7:6] = 00 (read setup): addr <= {cpu_din[5:0], latch}; pend <= 1, pend_we <= 0 (prefetch).
  - cpu_din[7:6] = 01 (write setup): addr <= {cpu_din[5:0], latch}; no VRAM access.
- Data write: toggle <= 0; pend <= 1, pend_we <= 1, pend_data <= cpu_din; read_buf <= cpu_din.
- Data read: toggle <= 0; cpu_dout shows read_buf this cycle; pend <= 1, pend_we <= 0 (next prefetch).
- Status read: cpu_dout = {F, 1'b0, C, 5'b0} (pre-clear value); F <= 0, C <= 0, toggle <= 0. Allowed while busy.
- While busy, data-port accesses and address-setup second bytes are dropped (toggle still clears) and overrun <= 1.
- Flags: vblank sets F, coll sets C; set wins over status-read clear in the same cycle.
- Arbitration each cycle with pend = 1: CPU slot if !vid_req or starve_cnt = STARVE_MAX; else video wins and starve_cnt increments. Without pend, video wins whenever vid_req; starve_cnt = 0.
- CPU slot: vram_addr = addr, vram_we = pend_we, vram_wdata = pend_data; addr <= addr + 1 (wraps 0x3FFF -> 0x0000); pend <= 0; starve_cnt <= 0; if read, rd_cap <= 1.
- rd_cap cycle: read_buf <= vram_rdata; rd_cap <= 0.
- vid_gnt = vid_req and not CPU slot; vram_addr = vid_addr, vram_we = 0 when video granted.

## Timing

- Reset values: regs 0, addr 0, latch 0, toggle 0, read_buf 0, F/C 0, pend/rd_cap 0, starve_cnt 0, overrun 0; outputs n_int = 1, busy = 0, vram_we = 0, vid_gnt = vid_req.
- Strobe at cycle T -> pend visible T+1; CPU slot earliest T+1, latest T+1+STARVE_MAX; read data in read_buf at slot+2 (captured at slot+1 edge).
- busy = pend | rd_cap; high from T+1 through the rd_cap cycle.
- Register writes visible on regs at T+1; n_int registered-free: combinational from F and reg1[5].
- Reset asserted mid-access aborts pend/rd_cap; no VRAM write issued in the reset cycle.

## Test plan

- Control 0x00,0x41 then data write 0xAA with vid_req = 0 -> vram_we at T+1 with addr 0x0100, data 0xAA; addr becomes 0x0101.
- Control 0x34,0x12 (read setup) with VRAM[0x1234] = 0x5C -> read_buf = 0x5C two cycles after slot, addr = 0x1235; subsequent data read returns 0x5C.
- Control 0xE0,0x81 -> regs[15:8] = 0xE0; then vblank pulse -> n_int = 0; status read returns 0x80, n_int = 1 next cycle.
- vid_req held high, data write issued -> video granted 3 cycles, CPU slot on 4th, vid_gnt = 0 that cycle.
- Write setup at 0x3FFF, two data writes -> second write lands at 0x0000.
- Data write while busy -> no extra VRAM write, overrun = 1; status read mid-sequence clears toggle so next control byte is treated as first.
